// File: rtl/hl_instr_arbiter_pkg.sv
// hl_instr_arbiter_pkg: shared types, opcodes and helpers for the high/low CPU instruction arbiter
package hl_instr_arbiter_pkg;
    typedef logic [11:0] instr_t;
    typedef logic req_id_t;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
    localparam logic [2:0] ILLEGAL_OPCODE = 3'b111;
    localparam logic [2:0] SKIP_OPCODE = 3'b110;
    function automatic logic [2:0] opcode(input instr_t i);
        return i[11:9];
    endfunction
    function automatic logic is_skip(input instr_t i);
        return opcode(i) == SKIP_OPCODE;
    endfunction
    function automatic logic is_illegal(input instr_t i);
        return opcode(i) == ILLEGAL_OPCODE;
    endfunction
endpackage

// File: rtl/hl_instr_arbiter_fifo.sv
// hl_instr_fifo: synchronous instr_t FIFO
// ports: clk, rst_n (async low); push/din in; pop in, dout = head; full, empty, count status
module hl_instr_fifo
    import hl_instr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  instr_t                 din,
    input  logic                   pop,
    output instr_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    instr_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & !full;
    assign do_pop = pop & !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/hl_instr_arbiter.sv
// hl_instr_arbiter: round-robin share of the CPU instruction port between two requesters with SKIP_NEXT lock
// ports: reqN_valid/reqN_ready/reqN_instr per requester; cpu_valid/cpu_ready/cpu_instr/cpu_src to the CPU;
//        lock_active = SKIP_NEXT lock held; illegal[N] = one-cycle pulse when requester N drops an opcode-111 instruction
module hl_instr_arbiter
    import hl_instr_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  instr_t     req0_instr,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  instr_t     req1_instr,
    output logic       cpu_valid,
    input  logic       cpu_ready,
    output instr_t     cpu_instr,
    output req_id_t    cpu_src,
    output logic       lock_active,
    output logic [1:0] illegal
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    instr_t head [2];
    logic [CW-1:0] count [2];
    logic [1:0] full, empty, push, pop, bad, elig, cand;
    logic stage_free, grant;
    req_id_t gid, owner, rr_ptr;
    lock_state_t lock_st;
    instr_t gnt_instr;
    assign req0_ready = count[0] < CW'(FIFO_DEPTH);
    assign req1_ready = count[1] < CW'(FIFO_DEPTH);
    assign push = {req1_valid & !full[1], req0_valid & !full[0]};
    hl_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk(clk), .rst_n(rst_n), .push(push[0]), .din(req0_instr), .pop(pop[0]),
        .dout(head[0]), .full(full[0]), .empty(empty[0]), .count(count[0])
    );
    hl_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .push(push[1]), .din(req1_instr), .pop(pop[1]),
        .dout(head[1]), .full(full[1]), .empty(empty[1]), .count(count[1])
    );
    // Illegal heads are flushed whenever present, independent of lock and output stage.
    assign bad = {!empty[1] & is_illegal(head[1]), !empty[0] & is_illegal(head[0])};
    assign elig = lock_st == LOCKED ? (owner ? 2'b10 : 2'b01) : 2'b11;
    assign cand = ~empty & ~bad & elig;
    assign stage_free = !cpu_valid | cpu_ready;
    assign grant = stage_free & |cand;
    assign gid = cand[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign gnt_instr = head[gid];
    assign pop = bad | {grant & gid, grant & ~gid};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_valid <= 1'b0;
            cpu_instr <= '0;
            cpu_src <= '0;
            lock_st <= UNLOCKED;
            lock_active <= 1'b0;
            owner <= '0;
            rr_ptr <= '0;
            illegal <= '0;
        end else begin
            illegal <= bad;
            if (stage_free) cpu_valid <= grant;
            if (grant) begin
                cpu_instr <= gnt_instr;
                cpu_src <= gid;
                // A locked grant always comes from the owner, so owner reload is harmless.
                owner <= gid;
                lock_st <= is_skip(gnt_instr) ? LOCKED : UNLOCKED;
                lock_active <= is_skip(gnt_instr);
                if (lock_st == UNLOCKED) rr_ptr <= ~gid;
            end
        end
    end
endmodule

// File: tb/tb_hl_instr_arbiter.sv
// tb_hl_instr_arbiter: scoreboard bench with a queue-based reference model of the arbiter
module tb_hl_instr_arbiter;
    import hl_instr_arbiter_pkg::*;
    localparam int D = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    instr_t req0_instr, req1_instr, cpu_instr;
    logic cpu_valid, cpu_ready, cpu_src, lock_active;
    logic [1:0] illegal;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    hl_instr_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_instr(cpu_instr), .cpu_src(cpu_src),
        .lock_active(lock_active), .illegal(illegal)
    );
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask
    // Reference model: per-requester queues, lock/owner/preference flags, expected-output queue.
    instr_t q [2][$];
    logic [12:0] exp_q[$];
    bit m_valid, m_lock, m_owner, m_rr;
    logic [1:0] m_ill;
    task automatic step();
        bit room [2];
        bit ok [2];
        bit free;
        int g;
        instr_t w;
        for (int n = 0; n < 2; n++) begin
            room[n] = q[n].size() < D;
            ok[n] = q[n].size() > 0 && q[n][0][11:9] != 3'b111 && (!m_lock || int'(m_owner) == n);
        end
        m_ill = 2'b00;
        for (int n = 0; n < 2; n++) begin
            if (q[n].size() > 0 && q[n][0][11:9] == 3'b111) begin
                void'(q[n].pop_front());
                m_ill[n] = 1'b1;
            end
        end
        free = !m_valid || cpu_ready;
        g = -1;
        if (free) begin
            if (ok[int'(m_rr)]) g = int'(m_rr);
            else if (ok[1 - int'(m_rr)]) g = 1 - int'(m_rr);
        end
        if (g >= 0) begin
            w = q[g].pop_front();
            exp_q.push_back({g[0], w});
            m_valid = 1'b1;
            if (!m_lock) begin
                m_rr = (g == 0);
                if (w[11:9] == 3'b110) begin
                    m_lock = 1'b1;
                    m_owner = g[0];
                end
            end else begin
                m_lock = (w[11:9] == 3'b110);
            end
        end else if (free) begin
            m_valid = 1'b0;
        end
        if (req0_valid && room[0]) q[0].push_back(req0_instr);
        if (req1_valid && room[1]) q[1].push_back(req1_instr);
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q[0].delete();
            q[1].delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_lock = 1'b0;
            m_owner = 1'b0;
            m_rr = 1'b0;
            m_ill = 2'b00;
        end else begin
            step();
        end
    end
    // Monitor: compares the DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cpu_valid", 16'(cpu_valid), 16'(m_valid));
            check("lock_active", 16'(lock_active), 16'(m_lock));
            check("illegal", 16'(illegal), 16'(m_ill));
            check("req0_ready", 16'(req0_ready), 16'(q[0].size() < D));
            check("req1_ready", 16'(req1_ready), 16'(q[1].size() < D));
            check("exp_depth", 16'(exp_q.size()), 16'(cpu_valid));
            if (cpu_valid && exp_q.size() > 0) begin
                check("cpu_out", 16'({cpu_src, cpu_instr}), 16'(exp_q[0]));
                if (cpu_ready) void'(exp_q.pop_front());
            end
        end
    end
    task automatic drive(input logic v0, input instr_t i0, input logic v1, input instr_t i1, input logic rdy);
        @(posedge clk);
        #1;
        req0_valid = v0;
        req0_instr = i0;
        req1_valid = v1;
        req1_instr = i1;
        cpu_ready = rdy;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    endtask
    task automatic check_reset_outputs();
        check("rst_cpu_valid", 16'(cpu_valid), 16'h0);
        check("rst_cpu_instr", 16'(cpu_instr), 16'h0);
        check("rst_cpu_src", 16'(cpu_src), 16'h0);
        check("rst_lock", 16'(lock_active), 16'h0);
        check("rst_illegal", 16'(illegal), 16'h0);
        check("rst_req0_ready", 16'(req0_ready), 16'h1);
        check("rst_req1_ready", 16'(req1_ready), 16'h1);
    endtask
    function automatic instr_t rnd_instr();
        return instr_t'($urandom);
    endfunction
    initial begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_instr = '0;
        req1_instr = '0;
        cpu_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 12'h0AB, 1'b1, 12'h1CD, 1'b1);
        idle(6);
        drive(1'b1, 12'hC01, 1'b1, 12'h4EE, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 12'h000, 1'b1, 12'h4EE, 1'b1);
        drive(1'b1, 12'h0AB, 1'b1, 12'h4EE, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 12'h000, 1'b1, 12'h4EE, 1'b1);
        idle(6);
        drive(1'b1, 12'h0A1, 1'b1, 12'hC02, 1'b1);
        drive(1'b0, 12'h000, 1'b1, 12'hC03, 1'b1);
        drive(1'b0, 12'h000, 1'b1, 12'h6AA, 1'b1);
        idle(6);
        drive(1'b1, 12'hE00, 1'b0, 12'h000, 1'b1);
        drive(1'b1, 12'h0AB, 1'b0, 12'h000, 1'b1);
        idle(6);
        for (int i = 0; i < 5; i++) drive(1'b1, instr_t'(12'h0B0 + i), 1'b1, instr_t'(12'h1C0 + i), 1'b0);
        idle(8);
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                #2;
                rst_n = 1'b1;
            end
            drive(($urandom % 10) < 7, rnd_instr(), ($urandom % 10) < 7, rnd_instr(), ($urandom % 4) != 0);
        end
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
